// File: rtl/stack_queue_feeder.sv
// stack_queue_feeder: control stage in front of the LIFO/FIFO/BUFFER storage block.
// Converts a ready/valid write stream and a read-request line into storage strobes.
// It mirrors the storage occupancy and returns popped bytes as a rd_valid pulse.
// Optional statistics counters are enabled by defining FEEDER_STATS_EN.
module stack_queue_feeder #(
    parameter int DEPTH = 15,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       cfg_mode,
    input  logic             cfg_load,
    output logic             cfg_err,
    input  logic             wr_valid,
    input  logic [7:0]       wr_data,
    output logic             wr_ready,
    input  logic             rd_req,
    output logic             rd_valid,
    output logic [7:0]       rd_data,
    output logic             rd_err,
    output logic [CNT_W-1:0] count,
    output logic [1:0]       st_mode,
    output logic             st_ce_lifo,
    output logic             st_ce_fifo,
    output logic             st_ce_buffer,
    output logic [7:0]       st_din,
    output logic             st_push,
    output logic             st_pop,
`ifdef FEEDER_STATS_EN
    output logic [15:0]      stat_push,
    output logic [15:0]      stat_pop,
    output logic [15:0]      stat_err,
`endif
    input  logic [7:0]       st_dout
);

    typedef enum logic [1:0] {IDLE, PUSH, POP, CAPTURE} state_t;

    localparam logic [1:0] MODE_LIFO   = 2'd0;
    localparam logic [1:0] MODE_FIFO   = 2'd1;
    localparam logic [1:0] MODE_BUFFER = 2'd2;
    localparam logic [1:0] MODE_OFF    = 2'd3;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    state_t           state_q, state_d;
    logic [1:0]       mode_q;
    logic [CNT_W-1:0] count_q;
    logic [7:0]       din_q;
    logic [7:0]       buf_data_q;
    logic             buf_valid_q;
    logic             rd_valid_q;
    logic [7:0]       rd_data_q;
    logic             rd_err_q;
    logic             cfg_err_q;
    logic             wr_ready_c;
    logic             rd_err_set;
    logic             stack_mode;
    logic             cfg_ok;
    logic             wr_fire;

    assign stack_mode = (mode_q == MODE_LIFO) || (mode_q == MODE_FIFO);
    assign cfg_ok     = cfg_load && (state_q == IDLE) && (count_q == '0);
    assign wr_ready   = wr_ready_c && !reset;
    assign wr_fire    = wr_valid && wr_ready;

    // Next-state and write-ready decode; reads win over writes, and a pending cfg_load blocks writes
    always_comb begin
        state_d    = state_q;
        wr_ready_c = 1'b0;
        rd_err_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (stack_mode) begin
                    if (rd_req) begin
                        if (count_q != '0) state_d = POP;
                        else               rd_err_set = 1'b1;
                    end else if (!cfg_load) begin
                        wr_ready_c = (count_q < DEPTH_C);
                        if (wr_valid && (count_q < DEPTH_C)) state_d = PUSH;
                    end
                end else if (mode_q == MODE_BUFFER) begin
                    wr_ready_c = !cfg_load;
                end
            end
            PUSH:    state_d = IDLE;
            POP:     state_d = CAPTURE;
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State, mode, occupancy mirror and error pulse registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            mode_q    <= MODE_FIFO;
            count_q   <= '0;
            rd_err_q  <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_err_q  <= rd_err_set;
            cfg_err_q <= cfg_load && !cfg_ok;
            if (cfg_ok) mode_q <= cfg_mode;
            if (state_q == PUSH)     count_q <= count_q + CNT_W'(1);
            else if (state_q == POP) count_q <= count_q - CNT_W'(1);
        end
    end

    // Data path: latch write bytes for storage, run the BUFFER bypass, return read bytes
    always_ff @(posedge clk) begin
        if (reset) begin
            din_q       <= '0;
            buf_data_q  <= '0;
            buf_valid_q <= 1'b0;
            rd_valid_q  <= 1'b0;
            rd_data_q   <= '0;
        end else begin
            if (wr_fire && stack_mode) din_q <= wr_data;
            buf_valid_q <= wr_fire && (mode_q == MODE_BUFFER);
            if (wr_fire && (mode_q == MODE_BUFFER)) buf_data_q <= wr_data;
            rd_valid_q <= (state_q == CAPTURE) || buf_valid_q;
            if (state_q == CAPTURE)  rd_data_q <= st_dout;
            else if (buf_valid_q)    rd_data_q <= buf_data_q;
        end
    end

    assign cfg_err      = cfg_err_q;
    assign rd_err       = rd_err_q;
    assign rd_valid     = rd_valid_q;
    assign rd_data      = rd_data_q;
    assign count        = count_q;
    assign st_mode      = mode_q;
    assign st_ce_lifo   = (mode_q == MODE_LIFO);
    assign st_ce_fifo   = (mode_q == MODE_FIFO);
    assign st_ce_buffer = (mode_q == MODE_BUFFER);
    assign st_din       = (mode_q == MODE_BUFFER) ? wr_data : din_q;
    assign st_push      = (state_q == PUSH) && stack_mode;
    assign st_pop       = (state_q == POP) && stack_mode;

`ifdef FEEDER_STATS_EN
    logic [15:0] stat_push_q, stat_pop_q, stat_err_q;
    logic [16:0] err_sum;

    assign err_sum = {1'b0, stat_err_q} + 17'(rd_err_q) + 17'(cfg_err_q);

    // Saturating event counters for push strobes, pop strobes and error pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_push_q <= '0;
            stat_pop_q  <= '0;
            stat_err_q  <= '0;
        end else begin
            if (st_push && stat_push_q != 16'hFFFF) stat_push_q <= stat_push_q + 16'd1;
            if (st_pop && stat_pop_q != 16'hFFFF)   stat_pop_q  <= stat_pop_q + 16'd1;
            stat_err_q <= err_sum[16] ? 16'hFFFF : err_sum[15:0];
        end
    end

    assign stat_push = stat_push_q;
    assign stat_pop  = stat_pop_q;
    assign stat_err  = stat_err_q;
`endif

endmodule

// File: tb/tb_stack_queue_feeder.sv
// Testbench for stack_queue_feeder with a behavioural storage block on the st_* strobes.
module tb_stack_queue_feeder;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] cfg_mode;
    logic       cfg_load;
    logic       cfg_err;
    logic       wr_valid;
    logic [7:0] wr_data;
    logic       wr_ready;
    logic       rd_req;
    logic       rd_valid;
    logic [7:0] rd_data;
    logic       rd_err;
    logic [3:0] count;
    logic [1:0] st_mode;
    logic       st_ce_lifo, st_ce_fifo, st_ce_buffer;
    logic [7:0] st_din;
    logic       st_push, st_pop;
    logic [7:0] st_dout;
`ifdef FEEDER_STATS_EN
    logic [15:0] stat_push, stat_pop, stat_err;
`endif

    int errors = 0;
    int checks = 0;
    logic [7:0] ref_q[$];

    stack_queue_feeder #(.DEPTH(15), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .cfg_mode(cfg_mode), .cfg_load(cfg_load), .cfg_err(cfg_err),
        .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
        .rd_req(rd_req), .rd_valid(rd_valid), .rd_data(rd_data), .rd_err(rd_err),
        .count(count), .st_mode(st_mode), .st_ce_lifo(st_ce_lifo), .st_ce_fifo(st_ce_fifo),
        .st_ce_buffer(st_ce_buffer), .st_din(st_din), .st_push(st_push), .st_pop(st_pop),
`ifdef FEEDER_STATS_EN
        .stat_push(stat_push), .stat_pop(stat_pop), .stat_err(stat_err),
`endif
        .st_dout(st_dout)
    );

    always #5 clk = ~clk;

    // Storage block stand-in: ordering follows the mode the storage is told to use
    logic [7:0] mem[$];
    always @(posedge clk) begin
        if (reset) begin
            mem.delete();
            st_dout <= 8'h00;
        end else begin
            if (st_push) mem.push_back(st_din);
            if (st_pop && mem.size() > 0) begin
                if (st_mode == 2'd0) st_dout <= mem.pop_back();
                else                 st_dout <= mem.pop_front();
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [7:0] b, input string tag);
        int n = 0;
        wr_valid = 1'b1;
        wr_data  = b;
        #1;
        while (!wr_ready && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL %s wr_ready_timeout got=%b want=1", tag, wr_ready);
            wr_valid = 1'b0;
            return;
        end
        tick();
        wr_valid = 1'b0;
        #1;
        checks++;
        if ({st_push, st_pop, st_din} !== {1'b1, 1'b0, b}) begin
            errors++;
            $display("[TB] FAIL %s push_strobe got push=%b pop=%b din=%h want push=1 pop=0 din=%h",
                     tag, st_push, st_pop, st_din, b);
        end
        tick();
    endtask

    task automatic do_read(input logic [7:0] exp, input string tag);
        rd_req = 1'b1;
        #1;
        tick();
        rd_req = 1'b0;
        #1;
        checks++;
        if ({st_pop, st_push} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL %s pop_strobe got pop=%b push=%b want pop=1 push=0", tag, st_pop, st_push);
        end
        tick();
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s early_rd_valid got=%b want=0", tag, rd_valid);
        end
        tick();
        checks++;
        if ({rd_valid, rd_data} !== {1'b1, exp}) begin
            errors++;
            $display("[TB] FAIL %s rd_data got valid=%b data=%h want valid=1 data=%h", tag, rd_valid, rd_data, exp);
        end
        tick();
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL %s rd_valid_width got=%b want=0", tag, rd_valid);
        end
    endtask

    task automatic set_mode(input logic [1:0] m);
        cfg_mode = m;
        cfg_load = 1'b1;
        #1;
        tick();
        cfg_load = 1'b0;
        #1;
        checks++;
        if ({st_mode, cfg_err} !== {m, 1'b0}) begin
            errors++;
            $display("[TB] FAIL set_mode got mode=%0d cfg_err=%b want mode=%0d cfg_err=0", st_mode, cfg_err, m);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; cfg_mode = 2'd0; cfg_load = 1'b0; wr_valid = 1'b0; wr_data = 8'h00; rd_req = 1'b0;
        tick();
        tick();
        checks++;
        if ({count, st_mode, st_ce_lifo, st_ce_fifo, st_ce_buffer, st_push, st_pop, st_din,
             wr_ready, rd_valid, rd_data, rd_err, cfg_err} !==
            {4'd0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL reset_values got cnt=%0d mode=%0d ce=%b%b%b push=%b pop=%b din=%h wr_ready=%b rv=%b rd=%h rerr=%b cerr=%b",
                     count, st_mode, st_ce_lifo, st_ce_fifo, st_ce_buffer, st_push, st_pop, st_din,
                     wr_ready, rd_valid, rd_data, rd_err, cfg_err);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL post_reset_ready got=%b want=1", wr_ready);
        end
    endtask

    task automatic test_fifo();
        logic [7:0] vals [3] = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 3; i++) do_write(vals[i], "fifo_wr");
        checks++;
        if (count !== 4'd3) begin
            errors++;
            $display("[TB] FAIL fifo_count got=%0d want=3", count);
        end
        for (int i = 0; i < 3; i++) do_read(vals[i], "fifo_rd");
        checks++;
        if (count !== 4'd0) begin
            errors++;
            $display("[TB] FAIL fifo_drain got=%0d want=0", count);
        end
    endtask

    task automatic test_lifo();
        set_mode(2'd0);
        checks++;
        if ({st_ce_lifo, st_ce_fifo, st_ce_buffer} !== 3'b100) begin
            errors++;
            $display("[TB] FAIL lifo_ce got=%b%b%b want=100", st_ce_lifo, st_ce_fifo, st_ce_buffer);
        end
        do_write(8'hA1, "lifo_wr");
        do_write(8'hA2, "lifo_wr");
        do_read(8'hA2, "lifo_rd");
        do_read(8'hA1, "lifo_rd");
    endtask

    task automatic test_random(input logic [1:0] m);
        logic [7:0] b;
        logic [7:0] exp;
        set_mode(m);
        ref_q.delete();
        for (int i = 0; i < 24; i++) begin
            if (ref_q.size() == 0 || (ref_q.size() < 15 && $urandom_range(1, 0) == 1)) begin
                b = 8'($urandom);
                ref_q.push_back(b);
                do_write(b, "rand_wr");
            end else begin
                exp = (m == 2'd1) ? ref_q.pop_front() : ref_q.pop_back();
                do_read(exp, "rand_rd");
            end
            checks++;
            if (count !== 4'(ref_q.size())) begin
                errors++;
                $display("[TB] FAIL rand_count got=%0d want=%0d", count, ref_q.size());
            end
        end
        while (ref_q.size() > 0) begin
            exp = (m == 2'd1) ? ref_q.pop_front() : ref_q.pop_back();
            do_read(exp, "rand_drain");
        end
    endtask

    task automatic test_full();
        set_mode(2'd1);
        for (int i = 0; i < 15; i++) do_write(8'(i * 7 + 3), "full_wr");
        wr_valid = 1'b1;
        wr_data  = 8'hEE;
        #1;
        checks++;
        if ({count, wr_ready} !== {4'd15, 1'b0}) begin
            errors++;
            $display("[TB] FAIL full_state got cnt=%0d ready=%b want cnt=15 ready=0", count, wr_ready);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({st_push, count} !== {1'b0, 4'd15}) begin
                errors++;
                $display("[TB] FAIL full_hold got push=%b cnt=%0d want push=0 cnt=15", st_push, count);
            end
        end
        wr_valid = 1'b0;
        do_read(8'd3, "full_rd");
        #1;
        checks++;
        if (wr_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL full_reopen got=%b want=1", wr_ready);
        end
        for (int i = 1; i < 15; i++) do_read(8'(i * 7 + 3), "full_drain");
    endtask

    task automatic test_errors();
        rd_req = 1'b1;
        #1;
        tick();
        rd_req = 1'b0;
        #1;
        checks++;
        if ({rd_err, st_pop} !== 2'b10) begin
            errors++;
            $display("[TB] FAIL rd_err_pulse got err=%b pop=%b want err=1 pop=0", rd_err, st_pop);
        end
        tick();
        checks++;
        if ({rd_err, st_pop} !== 2'b00) begin
            errors++;
            $display("[TB] FAIL rd_err_width got err=%b pop=%b want 0 0", rd_err, st_pop);
        end
        do_write(8'h44, "err_wr");
        do_write(8'h55, "err_wr");
        cfg_mode = 2'd0;
        cfg_load = 1'b1;
        #1;
        tick();
        cfg_load = 1'b0;
        #1;
        checks++;
        if (cfg_err !== 1'b1) begin
            errors++;
            $display("[TB] FAIL cfg_err_pulse got=%b want=1", cfg_err);
        end
        tick();
        checks++;
        if ({cfg_err, st_mode} !== {1'b0, 2'd1}) begin
            errors++;
            $display("[TB] FAIL cfg_reject got err=%b mode=%0d want err=0 mode=1", cfg_err, st_mode);
        end
        do_read(8'h44, "err_drain");
        do_read(8'h55, "err_drain");
    endtask

    task automatic test_buffer();
        logic [7:0] b;
        set_mode(2'd2);
        for (int i = 0; i < 6; i++) begin
            b = (i == 0) ? 8'h5A : (i == 1) ? 8'hC3 : 8'($urandom);
            wr_valid = 1'b1;
            wr_data  = b;
            #1;
            checks++;
            if ({wr_ready, st_din} !== {1'b1, b}) begin
                errors++;
                $display("[TB] FAIL buf_accept got ready=%b din=%h want ready=1 din=%h", wr_ready, st_din, b);
            end
            tick();
            wr_valid = 1'b0;
            #1;
            checks++;
            if ({rd_valid, st_push, st_pop} !== 3'b000) begin
                errors++;
                $display("[TB] FAIL buf_gap got rv=%b push=%b pop=%b want 000", rd_valid, st_push, st_pop);
            end
            tick();
            checks++;
            if ({rd_valid, rd_data, count} !== {1'b1, b, 4'd0}) begin
                errors++;
                $display("[TB] FAIL buf_return got rv=%b data=%h cnt=%0d want rv=1 data=%h cnt=0",
                         rd_valid, rd_data, count, b);
            end
        end
        rd_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({rd_err, st_pop, rd_valid} !== 3'b000) begin
                errors++;
                $display("[TB] FAIL buf_rd_ignored got err=%b pop=%b rv=%b want 000", rd_err, st_pop, rd_valid);
            end
        end
        rd_req = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] b0, b1;
        b0 = 8'($urandom);
        b1 = 8'($urandom);
        wr_valid = 1'b1;
        wr_data  = b0;
        tick();
        wr_data  = b1;
        tick();
        wr_valid = 1'b0;
        #1;
        checks++;
        if ({rd_valid, rd_data} !== {1'b1, b0}) begin
            errors++;
            $display("[TB] FAIL b2b_first got rv=%b data=%h want rv=1 data=%h", rd_valid, rd_data, b0);
        end
        tick();
        checks++;
        if ({rd_valid, rd_data} !== {1'b1, b1}) begin
            errors++;
            $display("[TB] FAIL b2b_second got rv=%b data=%h want rv=1 data=%h", rd_valid, rd_data, b1);
        end
        tick();
    endtask

    task automatic test_off();
        set_mode(2'd3);
        wr_valid = 1'b1;
        wr_data  = 8'h99;
        rd_req   = 1'b1;
        #1;
        checks++;
        if ({st_ce_lifo, st_ce_fifo, st_ce_buffer, wr_ready} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL off_outputs got ce=%b%b%b ready=%b want 0000", st_ce_lifo, st_ce_fifo, st_ce_buffer, wr_ready);
        end
        tick();
        tick();
        checks++;
        if ({st_push, st_pop, rd_err, rd_valid, count} !== {4'b0000, 4'd0}) begin
            errors++;
            $display("[TB] FAIL off_quiet got push=%b pop=%b err=%b rv=%b cnt=%0d want all 0",
                     st_push, st_pop, rd_err, rd_valid, count);
        end
        wr_valid = 1'b0;
        rd_req   = 1'b0;
        set_mode(2'd1);
    endtask

    task automatic test_reset_in_pop();
        do_write(8'h77, "rst_wr");
        rd_req = 1'b1;
        #1;
        tick();
        rd_req = 1'b0;
        #1;
        checks++;
        if (st_pop !== 1'b1) begin
            errors++;
            $display("[TB] FAIL rst_pop_entry got=%b want=1", st_pop);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if ({count, rd_valid, st_pop, st_push} !== {4'd0, 3'b000}) begin
            errors++;
            $display("[TB] FAIL rst_abort got cnt=%0d rv=%b pop=%b push=%b want 0 0 0 0", count, rd_valid, st_pop, st_push);
        end
`ifdef FEEDER_STATS_EN
        checks++;
        if ({stat_push, stat_pop, stat_err} !== 48'd0) begin
            errors++;
            $display("[TB] FAIL rst_stats got push=%0d pop=%0d err=%0d want 0", stat_push, stat_pop, stat_err);
        end
`endif
        tick();
        checks++;
        if ({rd_valid, wr_ready, st_mode} !== {1'b0, 1'b1, 2'd1}) begin
            errors++;
            $display("[TB] FAIL rst_idle got rv=%b ready=%b mode=%0d want rv=0 ready=1 mode=1", rd_valid, wr_ready, st_mode);
        end
    endtask

    // Scenario sequence; ends with the single summary line
    initial begin
        test_reset();
        test_fifo();
        test_lifo();
        test_random(2'd0);
        test_random(2'd1);
        test_full();
        test_errors();
        test_buffer();
        test_back_to_back();
        test_off();
        test_reset_in_pop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
